// File: rtl/pitch_ratio_divider.sv
// Fixed-point pitch shift ratio target/detected from a restoring divider that
// produces one quotient bit per clock.
//
// Handshake: a request is accepted in IDLE on a rising edge of target_valid
// (high now, low on the previous clock). Edges seen while busy, or a level that
// stays high, start nothing. Each accepted request produces exactly one
// one-cycle ratio_valid pulse; ratio, saturated and div_zero hold their values
// until the next pulse.
module pitch_ratio_divider #(
    parameter int WIDTH     = 12,
    parameter int FRAC_BITS = 8,
    parameter int INT_BITS  = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          target_valid,
    input  logic [WIDTH-1:0]              target_val,
    input  logic [WIDTH-1:0]              detected_val,
    output logic                          busy,
    output logic [INT_BITS+FRAC_BITS-1:0] ratio,
    output logic                          ratio_valid,
    output logic                          saturated,
    output logic                          div_zero
);
    localparam int RATIO_W = INT_BITS + FRAC_BITS;
    localparam int N       = WIDTH + FRAC_BITS;
    localparam int CNT_W   = $clog2(N + 1);
    localparam logic [RATIO_W-1:0] UNITY = RATIO_W'(1) << FRAC_BITS;

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t               state_q, state_d;
    logic                 tv_q, tv_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [N-1:0]         dq_q, dq_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic                 valid_q, valid_d;
    logic                 sat_q, sat_d;
    logic                 dz_q, dz_d;

    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [N-1:0]         quot_next;

    // dq_q starts as the dividend; its MSB shifts into the remainder while
    // quotient bits shift in at the LSB, so after N steps it holds the quotient.
    always_comb begin
        trial     = {rem_q[WIDTH-1:0], dq_q[N-1]};
        q_bit     = (trial >= {1'b0, div_q});
        quot_next = {dq_q[N-2:0], q_bit};

        state_d = state_q;
        tv_d    = target_valid;
        rem_d   = rem_q;
        dq_d    = dq_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ratio_d = ratio_q;
        valid_d = 1'b0;
        sat_d   = sat_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (target_valid && !tv_q) begin
                    dq_d  = {target_val, {FRAC_BITS{1'b0}}};
                    div_d = detected_val;
                    rem_d = '0;
                    cnt_d = '0;
                    if (detected_val == '0) begin
                        ratio_d = UNITY;
                        dz_d    = 1'b1;
                        sat_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                rem_d = q_bit ? (trial - {1'b0, div_q}) : trial;
                dq_d  = quot_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    dz_d    = 1'b0;
                    if (|quot_next[N-1:RATIO_W]) begin
                        ratio_d = '1;
                        sat_d   = 1'b1;
                    end else begin
                        ratio_d = quot_next[RATIO_W-1:0];
                        sat_d   = 1'b0;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            tv_q    <= 1'b0;
            rem_q   <= '0;
            dq_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ratio_q <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tv_q    <= tv_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ratio_q <= ratio_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = busy_q;
    assign ratio       = ratio_q;
    assign ratio_valid = valid_q;
    assign saturated   = sat_q;
    assign div_zero    = dz_q;
endmodule

// File: tb/tb_pitch_ratio_divider.sv
// Directed and randomized requests against an arithmetic reference of the
// target/detected ratio, with latency, busy duration and pulse-count checks.
module tb_pitch_ratio_divider;
    localparam int WIDTH = 12;
    localparam int FRAC  = 8;
    localparam int INTB  = 2;
    localparam int RW    = INTB + FRAC;

    logic            clk;
    logic            rst;
    logic            target_valid;
    logic [WIDTH-1:0] target_val;
    logic [WIDTH-1:0] detected_val;
    logic            busy;
    logic [RW-1:0]   ratio;
    logic            ratio_valid;
    logic            saturated;
    logic            div_zero;

    int errors = 0;
    int checks = 0;

    pitch_ratio_divider #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .INT_BITS(INTB)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .target_valid (target_valid),
        .target_val   (target_val),
        .detected_val (detected_val),
        .busy         (busy),
        .ratio        (ratio),
        .ratio_valid  (ratio_valid),
        .saturated    (saturated),
        .div_zero     (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: floor(target * 2^FRAC / detected), clipped to the Q2.8 range;
    // a zero divisor yields unity with the div_zero flag.
    task automatic model(input int t, input int d, output int r, output int s, output int z);
        int q;
        if (d == 0) begin
            r = 1 << FRAC; s = 0; z = 1;
        end else begin
            q = (t * (1 << FRAC)) / d;
            if (q > (1 << RW) - 1) begin
                r = (1 << RW) - 1; s = 1;
            end else begin
                r = q; s = 0;
            end
            z = 0;
        end
    endtask

    // Issues one request with target_valid held for 'hold' clocks; optionally
    // raises a second request edge at cycle inj_at (ignored by the DUT).
    task automatic run_req(input string tag, input int t, input int d, input int hold, input int inj_at);
        int er, es, ez;
        int lat, busy_cnt, vcnt;
        int gr, gs, gz;
        model(t, d, er, es, ez);
        lat = 0; busy_cnt = 0; vcnt = 0; gr = 0; gs = 0; gz = 0;
        @(negedge clk);
        target_val   = WIDTH'(t);
        detected_val = WIDTH'(d);
        target_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == hold) target_valid = 1'b0;
            if (inj_at != 0 && c == inj_at) begin
                target_val   = 12'd220;
                detected_val = 12'd110;
                target_valid = 1'b1;
            end
            if (inj_at != 0 && c == inj_at + 1) target_valid = 1'b0;
            if (busy) busy_cnt++;
            if (ratio_valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    lat = c; gr = int'(ratio); gs = int'(saturated); gz = int'(div_zero);
                end
            end
        end
        check({tag, " valid_count"}, vcnt, 1);
        check({tag, " latency"}, lat, (d == 0) ? 1 : WIDTH + FRAC + 1);
        check({tag, " busy_cycles"}, busy_cnt, (d == 0) ? 0 : WIDTH + FRAC);
        check({tag, " ratio"}, gr, er);
        check({tag, " saturated"}, gs, es);
        check({tag, " div_zero"}, gz, ez);
        check({tag, " ratio_held"}, ratio, er);
    endtask

    initial begin
        int t, d, vseen;
        rst = 1'b1;
        target_valid = 1'b0;
        target_val = '0;
        detected_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset ratio", ratio, 0);
        check("reset ratio_valid", ratio_valid, 0);
        check("reset saturated", saturated, 0);
        check("reset div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_req("440/415", 440, 415, 1, 0);
        run_req("100/300 hold4", 100, 300, 4, 0);
        run_req("2000/400 sat", 2000, 400, 1, 0);
        run_req("440/0", 440, 0, 1, 0);
        run_req("440/440", 440, 440, 2, 0);
        run_req("inject", 440, 415, 1, 5);
        run_req("max/1", 4095, 1, 1, 0);
        run_req("0/7", 0, 7, 1, 0);

        // Asynchronous reset after the tenth iteration of a divide.
        @(negedge clk);
        target_val = 12'd440; detected_val = 12'd415; target_valid = 1'b1;
        @(posedge clk);
        #1 target_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async rst busy", busy, 0);
        check("async rst ratio", ratio, 0);
        check("async rst ratio_valid", ratio_valid, 0);
        check("async rst saturated", saturated, 0);
        check("async rst div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        vseen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (ratio_valid || busy) vseen++;
        end
        check("post-reset quiet", vseen, 0);
        run_req("330/330", 330, 330, 1, 0);

        for (int i = 0; i < 30; i++) begin
            t = $urandom_range(0, 4095);
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4095);
            if ($urandom_range(0, 3) == 0 && d != 0) d = $urandom_range(1, 64);
            run_req("random", t, d, $urandom_range(1, 5), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pitch_ratio_divider.md
Name: pitch_ratio_divider

Overview:
- Downstream stage of the semitone searcher.
- Captures the snapped semitone value and the detected pitch value, and computes the fixed-point shift ratio target/detected with a sequential restoring divider.
- Feeds the ratio to the pitch-shifter resampler.
- Uses a start-on-rising-edge / one-cycle-valid handshake, so it tolerates the searcher's multi-cycle found strobe.

Parameters:
- WIDTH, 12, bit width of target_val and detected_val (matches searcher WIDTH).
- FRAC_BITS, 8, fractional bits of ratio.
- INT_BITS, 2, integer bits of ratio; RATIO_W = INT_BITS+FRAC_BITS.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- target_valid  input  1  connects to searcher closest_value_found; may stay high for several cycles
- target_val  input  WIDTH  snapped semitone value (searcher closest_value)
- detected_val  input  WIDTH  detected pitch value that was searched
- busy  output  1  high while a division is in progress
- ratio  output  RATIO_W  unsigned Q(INT_BITS.FRAC_BITS) result, held until the next result
- ratio_valid  output  1  one-cycle pulse when ratio updates
- saturated  output  1  last result was clipped to the maximum; valid with ratio
- div_zero  output  1  last result came from detected_val==0; valid with ratio

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, ratio=0, ratio_valid=0, saturated=0, div_zero=0; edge-detect register=0; all internal divider registers cleared. Reset mid-division aborts it with no ratio_valid.
- Start: a rising edge of target_valid (high now, registered copy low) sampled in IDLE is cycle k.
  - In cycle k, target_val and detected_val are latched.
  - Rising edges while busy=1 are ignored, and so is a level that stays high after completion.
- State DIVIDE (detected_val != 0):
  - Dividend D = target_val << FRAC_BITS, width WIDTH+FRAC_BITS. Divisor = detected_val.
  - Restoring division, one quotient bit per cycle, MSB first: remainder = {remainder, next dividend bit}; if remainder >= divisor, subtract and set the quotient bit.
  - Q = WIDTH+FRAC_BITS iterations; busy=1 throughout.
- Completion, state DONE:
  - Full quotient width is WIDTH+FRAC_BITS. If any bit above RATIO_W-1 is set: ratio = all ones and saturated=1. Otherwise ratio = quotient[RATIO_W-1:0] and saturated=0.
  - Result is floor; no rounding.
  - ratio_valid=1 for exactly the one cycle k+Q+1; busy drops in that same cycle; return to IDLE.
- Divide by zero (detected_val==0 at capture):
  - No iterations.
  - In cycle k+1: ratio = 1<<FRAC_BITS (unity, no shift), div_zero=1, saturated=0, ratio_valid pulse. busy is never asserted.
- Flags saturated and div_zero update only together with ratio_valid.
- Back-to-back: a new rising edge is accepted the cycle after ratio_valid, once in IDLE.

Test Plan:
- WIDTH=12, FRAC=8, INT=2; target_valid rising with target=440, detected=415 -> ratio=271 (0x10F), saturated=0, ratio_valid single pulse 21 cycles after the capture cycle.
- target=100, detected=300 -> ratio=85, busy high 20 cycles; target_valid held high 4 cycles produces exactly one result.
- target=2000, detected=400 (true quotient 1280) -> ratio=1023, saturated=1.
- target=440, detected=0 -> next cycle ratio=256, div_zero=1, busy never high; the following normal divide (440/440) gives ratio=256, div_zero=0.
- Second rising edge mid-divide (target=220, detected=110) -> ignored; the first result (440/415=271) is delivered unchanged and no second ratio_valid follows.
- Assert rst_in asynchronously at iteration 10 -> all outputs 0 immediately, no ratio_valid; after release, a new request (330/330) yields 256 at normal latency.
